rx_frame_fifo: RTL and testbench

//  Downstream stage of the UART receiver. Captures each completed receive frame (8-bit data plus

---
 rtl/uart_pkg.sv | 10 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/rx_frame_fifo.sv | 92 +++++++++
 tb/tb_rx_frame_fifo.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: payload width, FIFO geometry
// and the layout of a stored receive entry.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_ADDR_W = 4;
    localparam int ENTRY_W     = UART_DATA_W + 2;
    localparam int PAR_BIT     = UART_DATA_W;
    localparam int STOP_BIT    = UART_DATA_W + 1;
endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock show-ahead FIFO: the head entry is presented on rd_data
// whenever the FIFO is non-empty, and rd_en pops it at the clock edge.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH  = ENTRY_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr_reg;
    logic [ADDR_W:0]  rd_ptr_reg;
    logic             rd_ok;
    logic             wr_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                   (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
    assign count = wr_ptr_reg - rd_ptr_reg;

    assign rd_ok = rd_en & ~empty;
    // A write into a full FIFO is accepted only when a pop frees a slot at the same edge.
    assign wr_ok = wr_en & (~full | rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage is not reset, so the head is forced to zero while nothing is held.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg[ADDR_W-1:0]];
endmodule

// File: rtl/rx_frame_fifo.sv
// Captures completed UART receive frames (data plus parity/stop flags) into a
// show-ahead FIFO and hands them to the host over valid/ready, flagging overrun.
module rx_frame_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_parity_error,
    input  logic              rx_stop_error,
    output logic [DATA_W-1:0] dout,
    output logic              dout_parity_err,
    output logic              dout_stop_err,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overrun,
    input  logic              overrun_clr
);
    localparam int ENT_W    = DATA_W + 2;
    localparam int PAR_IDX  = DATA_W;
    localparam int STOP_IDX = DATA_W + 1;

    logic             edge_reg;
    logic             parity_reg;
    logic             overrun_reg;
    logic             strobe;
    logic             frame_event;
    logic             pop;
    logic             wr_en;
    logic             drop;
    logic             empty;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] head;

    assign strobe      = rx_valid | rx_stop_error;
    assign frame_event = strobe & ~edge_reg;
    assign pop         = dout_valid & dout_ready;
    assign wr_en       = frame_event & (~full | pop);
    assign drop        = frame_event & full & ~pop;
    assign wr_entry    = {rx_stop_error, parity_reg | rx_parity_error, rx_data};

    // edge_reg resets high so a strobe already asserted at reset release is not a new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_reg    <= 1'b1;
            parity_reg  <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            edge_reg <= strobe;
            if (wr_en) begin
                parity_reg <= 1'b0;
            end else if (rx_parity_error) begin
                parity_reg <= 1'b1;
            end
            // A new drop outranks a clear in the same cycle.
            if (drop) begin
                overrun_reg <= 1'b1;
            end else if (overrun_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH  (ENT_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign dout_valid      = ~empty;
    assign dout            = head[DATA_W-1:0];
    assign dout_parity_err = head[PAR_IDX];
    assign dout_stop_err   = head[STOP_IDX];
    assign overrun         = overrun_reg;
endmodule

// File: tb/tb_rx_frame_fifo.sv
// Directed bench for rx_frame_fifo with a queue scoreboard of expected entries.
module tb_rx_frame_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_error;
    logic       rx_stop_error;
    logic [7:0] dout;
    logic       dout_parity_err;
    logic       dout_stop_err;
    logic       dout_valid;
    logic       dout_ready;
    logic [4:0] count;
    logic       full;
    logic       overrun;
    logic       overrun_clr;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb [$];

    always #5 clk = ~clk;

    rx_frame_fifo dut (
        .clk             (clk),
        .reset           (reset),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_parity_error (rx_parity_error),
        .rx_stop_error   (rx_stop_error),
        .dout            (dout),
        .dout_parity_err (dout_parity_err),
        .dout_stop_err   (dout_stop_err),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .count           (count),
        .full            (full),
        .overrun         (overrun),
        .overrun_clr     (overrun_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clean frame: rx_valid high for one cycle, then low for one cycle.
    task automatic send(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    // Compare head with scoreboard front, pop it, then check occupancy.
    task automatic pop_check(input string tag);
        logic [9:0] exp;
        exp = sb.pop_front();
        check({tag, "_valid"}, {31'd0, dout_valid}, 32'd1);
        check({tag, "_entry"}, {22'd0, dout_stop_err, dout_parity_err, dout}, {22'd0, exp});
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check({tag, "_count"}, {27'd0, count}, sb.size());
        $display("pop %s entry=%03h remaining=%0d", tag, exp, sb.size());
    endtask

    initial begin
        reset = 1'b1;
        rx_data = '0; rx_valid = 0; rx_parity_error = 0; rx_stop_error = 0;
        dout_ready = 0; overrun_clr = 0;
        tick();
        check("rst_outputs", {17'd0, dout, dout_parity_err, dout_stop_err, dout_valid, count, full, overrun},
              32'd0);
        reset = 1'b0;
        tick();

        // 1: long rx_valid gives exactly one entry
        rx_data = 8'hA5; rx_valid = 1'b1;
        tick(); tick(); tick();
        rx_valid = 1'b0;
        tick();
        sb.push_back({2'b00, 8'hA5});
        check("t1_count", {27'd0, count}, 32'd1);
        pop_check("t1");

        // 2: parity pulse precedes the frame; following clean frame has no flag
        rx_parity_error = 1'b1; tick();
        rx_parity_error = 1'b0; tick(); tick();
        send(8'h3C); sb.push_back({2'b01, 8'h3C});
        send(8'h11); sb.push_back({2'b00, 8'h11});
        check("t2_count", {27'd0, count}, 32'd2);
        pop_check("t2a");
        pop_check("t2b");

        // 3: stop error alone stores a frame; dout_ready held while empty is write-only
        rx_data = 8'h00; rx_stop_error = 1'b1; dout_ready = 1'b1;
        tick();
        rx_stop_error = 1'b0; dout_ready = 1'b0;
        sb.push_back({2'b10, 8'h00});
        check("t3_count", {27'd0, count}, 32'd1);
        tick();
        pop_check("t3");
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;
        check("t3_empty_ready", {27'd0, count}, 32'd0);

        // 4: fill, overrun on the 17th frame, drain in order, clear overrun
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
            sb.push_back({2'b00, 8'(i)});
        end
        check("t4_full", {31'd0, full}, 32'd1);
        check("t4_count16", {27'd0, count}, 32'd16);
        check("t4_no_overrun", {31'd0, overrun}, 32'd0);
        send(8'h99);
        check("t4_overrun", {31'd0, overrun}, 32'd1);
        check("t4_count_drop", {27'd0, count}, 32'd16);
        for (int i = 0; i < 16; i++) pop_check("t4_drain");
        check("t4_empty", {31'd0, dout_valid}, 32'd0);
        check("t4_overrun_sticky", {31'd0, overrun}, 32'd1);
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
        check("t4_overrun_clr", {31'd0, overrun}, 32'd0);

        // 5: full with a coincident event and pop
        for (int i = 0; i < 16; i++) begin
            send(8'(8'h20 + i));
            sb.push_back({2'b00, 8'(8'h20 + i)});
        end
        check("t5_full", {31'd0, full}, 32'd1);
        check("t5_head", {24'd0, dout}, {24'd0, sb[0][7:0]});
        rx_data = 8'hEE; rx_valid = 1'b1; dout_ready = 1'b1;
        tick();
        rx_valid = 1'b0; dout_ready = 1'b0;
        void'(sb.pop_front());
        sb.push_back({2'b00, 8'hEE});
        check("t5_overrun", {31'd0, overrun}, 32'd0);
        check("t5_count", {27'd0, count}, 32'd16);
        tick();
        for (int i = 0; i < 16; i++) pop_check("t5_drain");

        // 6: reset mid-operation and rx_valid held across release
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h50 + i));
            sb.push_back({2'b00, 8'(8'h50 + i)});
        end
        check("t6_count5", {27'd0, count}, 32'd5);
        reset = 1'b1;
        #1;
        check("t6_rst_count", {27'd0, count}, 32'd0);
        check("t6_rst_valid", {31'd0, dout_valid}, 32'd0);
        sb.delete();
        rx_valid = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick();
        check("t6_no_write", {27'd0, count}, 32'd0);
        rx_valid = 1'b0;
        tick();
        send(8'h77); sb.push_back({2'b00, 8'h77});
        check("t6_after_count", {27'd0, count}, 32'd1);
        pop_check("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
